sal_bk_sched: RTL and testbench

- Multi-bank command scheduler between BK_CNT per-bank controllers and the single DFI command bus.
- Generalises the single-bank path: N bank request channels, class-priority plus round-robin arbitration, and inter-bank timing enforcement (tRRD, tCCD, tWTR, tRTW).
- Grants at most one bank command per cycle and drives registered DDR2 command pins.

---
 rtl/sal_sched_pkg.sv | 25 ++
 rtl/sal_rr_arbiter.sv | 31 +++
 rtl/sal_bk_sched.sv | 178 +++++++++++++++++
 tb/tb_sal_bk_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sal_sched_pkg.sv
// Shared types, DDR2 pin encodings and timer helpers for the sal_bk_sched scheduler.
package sal_sched_pkg;

   typedef enum logic [1:0] {
      CMD_ACT = 2'd0,
      CMD_RD  = 2'd1,
      CMD_WR  = 2'd2,
      CMD_PRE = 2'd3
   } cmd_t;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] PINS_ACT = 4'b0011;
   localparam logic [3:0] PINS_RD  = 4'b0101;
   localparam logic [3:0] PINS_WR  = 4'b0100;
   localparam logic [3:0] PINS_PRE = 4'b0010;
   localparam logic [3:0] PINS_NOP = 4'b1111;

   localparam int DEF_TIMER_W = 4;

   // A counter loaded with t-1 reaches zero exactly t cycles after the issue.
   function automatic logic [15:0] timer_load(input logic [15:0] t);
      return (t == 16'd0) ? 16'd0 : t - 16'd1;
   endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module sal_rr_arbiter #(
   parameter int BK_CNT = 4,
   parameter int BK_W   = $clog2(BK_CNT)
) (
   input  logic [BK_CNT-1:0] req_i,
   input  logic [BK_W-1:0]   ptr_i,
   output logic [BK_CNT-1:0] gnt_o,
   output logic [BK_W-1:0]   idx_o,
   output logic              any_o
);

   logic [BK_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      // BK_CNT is a power of two, so the index addition wraps naturally.
      for (int i = 0; i < BK_CNT; i++) begin
         cand = ptr_i + BK_W'(i);
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      gnt_o[idx_o] = any_o;
   end

endmodule

// File: rtl/sal_bk_sched.sv
// Multi-bank DFI command scheduler: class priority (CAS > ACT > PRE), round-robin
// within a class, tRRD/tCCD/tWTR/tRTW spacing. Optional tFAW window: SAL_SCHED_FAW_EN.
module sal_bk_sched
   import sal_sched_pkg::*;
#(
   parameter int BK_CNT  = 4,
   parameter int BK_W    = $clog2(BK_CNT),
   parameter int ADDR_W  = 14,
   parameter int TIMER_W = DEF_TIMER_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [BK_CNT-1:0]        bk_req_valid_i,
   input  logic [2*BK_CNT-1:0]      bk_req_cmd_i,
   input  logic [ADDR_W*BK_CNT-1:0] bk_req_addr_i,
   output logic [BK_CNT-1:0]        bk_req_ready_o,
   input  logic [TIMER_W-1:0]       t_rrd_i,
   input  logic [TIMER_W-1:0]       t_ccd_i,
   input  logic [TIMER_W-1:0]       t_wtr_i,
   input  logic [TIMER_W-1:0]       t_rtw_i,
   input  logic [TIMER_W+1:0]       t_faw_i,
   output logic                     dfi_cs_n_o,
   output logic                     dfi_ras_n_o,
   output logic                     dfi_cas_n_o,
   output logic                     dfi_we_n_o,
   output logic [BK_W-1:0]          dfi_bank_o,
   output logic [ADDR_W-1:0]        dfi_address_o
);

   logic [TIMER_W-1:0] rrd_cnt_q, rrd_cnt_d;
   logic [TIMER_W-1:0] ccd_cnt_q, ccd_cnt_d;
   logic [TIMER_W-1:0] wtr_cnt_q, wtr_cnt_d;
   logic [TIMER_W-1:0] rtw_cnt_q, rtw_cnt_d;
   logic [BK_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [3:0]         pins_q, pins_d;
   logic [BK_W-1:0]    bank_q, bank_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;

   logic [BK_CNT-1:0] cas_req, act_req, pre_req;
   logic [BK_CNT-1:0] cas_gnt, act_gnt, pre_gnt, gnt;
   logic [BK_W-1:0]   cas_idx, act_idx, pre_idx, gnt_idx;
   logic              cas_any, act_any, pre_any, gnt_any;
   logic              faw_ok, act_issue;
   cmd_t              gnt_cmd;
   logic [ADDR_W-1:0] gnt_addr;

   generate
      for (genvar gi = 0; gi < BK_CNT; gi++) begin : g_bank
         cmd_t cmd;
         assign cmd = cmd_t'(bk_req_cmd_i[2*gi +: 2]);
         assign cas_req[gi] = bk_req_valid_i[gi] && (ccd_cnt_q == '0) &&
                              ((cmd == CMD_RD && wtr_cnt_q == '0) ||
                               (cmd == CMD_WR && rtw_cnt_q == '0));
         assign act_req[gi] = bk_req_valid_i[gi] && (cmd == CMD_ACT) &&
                              (rrd_cnt_q == '0) && faw_ok;
         assign pre_req[gi] = bk_req_valid_i[gi] && (cmd == CMD_PRE);
      end
   endgenerate

   sal_rr_arbiter #(.BK_CNT(BK_CNT), .BK_W(BK_W)) u_arb_cas (
      .req_i(cas_req), .ptr_i(rr_ptr_q), .gnt_o(cas_gnt), .idx_o(cas_idx), .any_o(cas_any));
   sal_rr_arbiter #(.BK_CNT(BK_CNT), .BK_W(BK_W)) u_arb_act (
      .req_i(act_req), .ptr_i(rr_ptr_q), .gnt_o(act_gnt), .idx_o(act_idx), .any_o(act_any));
   sal_rr_arbiter #(.BK_CNT(BK_CNT), .BK_W(BK_W)) u_arb_pre (
      .req_i(pre_req), .ptr_i(rr_ptr_q), .gnt_o(pre_gnt), .idx_o(pre_idx), .any_o(pre_any));

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (cas_any) begin
         gnt = cas_gnt; gnt_idx = cas_idx; gnt_any = 1'b1;
      end else if (act_any) begin
         gnt = act_gnt; gnt_idx = act_idx; gnt_any = 1'b1;
      end else if (pre_any) begin
         gnt = pre_gnt; gnt_idx = pre_idx; gnt_any = 1'b1;
      end
   end

   // Counters clear while rst_n is low, so ready must be masked explicitly.
   assign bk_req_ready_o = gnt & {BK_CNT{rst_n}};
   assign gnt_cmd        = cmd_t'(bk_req_cmd_i[2*gnt_idx +: 2]);
   assign gnt_addr       = bk_req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
   assign act_issue      = gnt_any && (gnt_cmd == CMD_ACT);

   always_comb begin
      pins_d    = PINS_NOP;
      bank_d    = bank_q;
      addr_d    = addr_q;
      rr_ptr_d  = rr_ptr_q;
      rrd_cnt_d = (rrd_cnt_q == '0) ? rrd_cnt_q : rrd_cnt_q - 1'b1;
      ccd_cnt_d = (ccd_cnt_q == '0) ? ccd_cnt_q : ccd_cnt_q - 1'b1;
      wtr_cnt_d = (wtr_cnt_q == '0) ? wtr_cnt_q : wtr_cnt_q - 1'b1;
      rtw_cnt_d = (rtw_cnt_q == '0) ? rtw_cnt_q : rtw_cnt_q - 1'b1;
      if (gnt_any) begin
         bank_d   = gnt_idx;
         addr_d   = gnt_addr;
         rr_ptr_d = gnt_idx + BK_W'(1);
         case (gnt_cmd)
            CMD_ACT: begin
               pins_d    = PINS_ACT;
               rrd_cnt_d = TIMER_W'(timer_load(16'(t_rrd_i)));
            end
            CMD_RD: begin
               pins_d    = PINS_RD;
               ccd_cnt_d = TIMER_W'(timer_load(16'(t_ccd_i)));
               rtw_cnt_d = TIMER_W'(timer_load(16'(t_rtw_i)));
            end
            CMD_WR: begin
               pins_d    = PINS_WR;
               ccd_cnt_d = TIMER_W'(timer_load(16'(t_ccd_i)));
               wtr_cnt_d = TIMER_W'(timer_load(16'(t_wtr_i)));
            end
            default: pins_d = PINS_PRE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pins_q    <= PINS_NOP;
         bank_q    <= '0;
         addr_q    <= '0;
         rr_ptr_q  <= '0;
         rrd_cnt_q <= '0;
         ccd_cnt_q <= '0;
         wtr_cnt_q <= '0;
         rtw_cnt_q <= '0;
      end else begin
         pins_q    <= pins_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
         rr_ptr_q  <= rr_ptr_d;
         rrd_cnt_q <= rrd_cnt_d;
         ccd_cnt_q <= ccd_cnt_d;
         wtr_cnt_q <= wtr_cnt_d;
         rtw_cnt_q <= rtw_cnt_d;
      end
   end

`ifdef SAL_SCHED_FAW_EN
   // Entry 0 is the newest ACT; with a fixed window the oldest (entry 3) expires first.
   logic [TIMER_W+1:0] faw_q [4];
   logic [TIMER_W+1:0] faw_d [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         faw_d[i] = (faw_q[i] == '0) ? faw_q[i] : faw_q[i] - 1'b1;
      end
      if (act_issue) begin
         faw_d[0] = (TIMER_W+2)'(timer_load(16'(t_faw_i)));
         for (int i = 1; i < 4; i++) begin
            faw_d[i] = (faw_q[i-1] == '0) ? faw_q[i-1] : faw_q[i-1] - 1'b1;
         end
      end
   end

   assign faw_ok = !((faw_q[0] != '0) && (faw_q[1] != '0) &&
                     (faw_q[2] != '0) && (faw_q[3] != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) faw_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) faw_q[i] <= faw_d[i];
      end
   end
`else
   logic unused_faw;
   assign faw_ok     = 1'b1;
   assign unused_faw = ^{t_faw_i, act_issue};
`endif

   assign {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} = pins_q;
   assign dfi_bank_o    = bank_q;
   assign dfi_address_o = addr_q;

endmodule

// File: tb/tb_sal_bk_sched.sv
// Table-driven bench for sal_bk_sched: one row per cycle, plus a hand-written reset sequence.
module tb_sal_bk_sched;

   localparam int BK_CNT = 4;
   localparam int ADDR_W = 14;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [BK_CNT-1:0]        bk_req_valid_i = '0;
   logic [2*BK_CNT-1:0]      bk_req_cmd_i = '0;
   logic [ADDR_W*BK_CNT-1:0] bk_req_addr_i = '0;
   logic [BK_CNT-1:0]        bk_req_ready_o;
   logic [3:0]               t_rrd_i = '0, t_ccd_i = '0, t_wtr_i = '0, t_rtw_i = '0;
   logic [5:0]               t_faw_i = '0;
   logic                     dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o;
   logic [1:0]               dfi_bank_o;
   logic [ADDR_W-1:0]        dfi_address_o;

   sal_bk_sched #(.BK_CNT(BK_CNT), .ADDR_W(ADDR_W), .TIMER_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .bk_req_valid_i(bk_req_valid_i), .bk_req_cmd_i(bk_req_cmd_i),
      .bk_req_addr_i(bk_req_addr_i), .bk_req_ready_o(bk_req_ready_o),
      .t_rrd_i(t_rrd_i), .t_ccd_i(t_ccd_i), .t_wtr_i(t_wtr_i), .t_rtw_i(t_rtw_i),
      .t_faw_i(t_faw_i),
      .dfi_cs_n_o(dfi_cs_n_o), .dfi_ras_n_o(dfi_ras_n_o), .dfi_cas_n_o(dfi_cas_n_o),
      .dfi_we_n_o(dfi_we_n_o), .dfi_bank_o(dfi_bank_o), .dfi_address_o(dfi_address_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [7:0]  cmd;
      logic [13:0] base;
      logic [3:0]  t_rrd, t_ccd, t_wtr, t_rtw;
      logic [5:0]  t_faw;
      logic [3:0]  exp_rdy;
      logic [3:0]  exp_pins;
      logic [1:0]  exp_bank;
      logic [13:0] exp_addr;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic [3:0] cur_rrd, cur_ccd, cur_wtr, cur_rtw;
   logic [5:0] cur_faw;

   function automatic logic [3:0] pins();
      return {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o};
   endfunction

   task automatic set_t(input logic [3:0] rrd, ccd, wtr, rtw, input logic [5:0] faw);
      cur_rrd = rrd; cur_ccd = ccd; cur_wtr = wtr; cur_rtw = rtw; cur_faw = faw;
   endtask

   task automatic add(input logic [3:0] valid, input logic [7:0] cmd, input logic [13:0] base,
                      input logic [3:0] rdy, input logic [3:0] p, input logic [1:0] bk,
                      input logic [13:0] addr);
      vec_t v;
      v.valid = valid; v.cmd = cmd; v.base = base;
      v.t_rrd = cur_rrd; v.t_ccd = cur_ccd; v.t_wtr = cur_wtr; v.t_rtw = cur_rtw;
      v.t_faw = cur_faw;
      v.exp_rdy = rdy; v.exp_pins = p; v.exp_bank = bk; v.exp_addr = addr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bk_req_valid_i = v.valid;
      bk_req_cmd_i   = v.cmd;
      for (int b = 0; b < BK_CNT; b++) bk_req_addr_i[b*ADDR_W +: ADDR_W] = v.base + 14'(b);
      t_rrd_i = v.t_rrd; t_ccd_i = v.t_ccd; t_wtr_i = v.t_wtr; t_rtw_i = v.t_rtw;
      t_faw_i = v.t_faw;
   endtask

   initial begin
      // Round-robin: all banks RD, t_ccd=1, from rr_ptr=0.
      set_t(4'd2, 4'd1, 4'd0, 4'd0, 6'd0);
      add(4'hF, 8'h55, 14'h200, 4'b0001, 4'hF, 2'd0, 14'h000);
      add(4'hF, 8'h55, 14'h200, 4'b0010, 4'h5, 2'd0, 14'h200);
      add(4'hF, 8'h55, 14'h200, 4'b0100, 4'h5, 2'd1, 14'h201);
      add(4'hF, 8'h55, 14'h200, 4'b1000, 4'h5, 2'd2, 14'h202);
      add(4'hF, 8'h55, 14'h200, 4'b0001, 4'h5, 2'd3, 14'h203);
      add(4'h0, 8'h55, 14'h200, 4'b0000, 4'h5, 2'd0, 14'h200);
      add(4'h0, 8'h55, 14'h200, 4'b0000, 4'hF, 2'd0, 14'h000);
      // Single bank: bank2 ACT 0x123 then RD 0x040.
      set_t(4'd2, 4'd2, 4'd0, 4'd0, 6'd0);
      add(4'b0100, 8'h00, 14'h121, 4'b0100, 4'hF, 2'd0, 14'h000);
      add(4'b0100, 8'h10, 14'h03E, 4'b0100, 4'h3, 2'd2, 14'h123);
      add(4'b0000, 8'h00, 14'h000, 4'b0000, 4'h5, 2'd2, 14'h040);
      add(4'b0000, 8'h00, 14'h000, 4'b0000, 4'hF, 2'd0, 14'h000);
      // Priority: bank0 PRE, bank1 ACT, bank3 WR.
      set_t(4'd1, 4'd1, 4'd0, 4'd0, 6'd0);
      add(4'b1011, 8'h83, 14'h300, 4'b1000, 4'hF, 2'd0, 14'h000);
      add(4'b0011, 8'h83, 14'h300, 4'b0010, 4'h4, 2'd3, 14'h303);
      add(4'b0001, 8'h83, 14'h300, 4'b0001, 4'h3, 2'd1, 14'h301);
      add(4'b0000, 8'h83, 14'h300, 4'b0000, 4'h2, 2'd0, 14'h300);
      add(4'b0000, 8'h83, 14'h300, 4'b0000, 4'hF, 2'd0, 14'h000);
      // tRRD=4 between ACTs on banks 1 and 0.
      set_t(4'd4, 4'd1, 4'd0, 4'd0, 6'd0);
      add(4'b0011, 8'h00, 14'h010, 4'b0010, 4'hF, 2'd0, 14'h000);
      add(4'b0001, 8'h00, 14'h010, 4'b0000, 4'h3, 2'd1, 14'h011);
      add(4'b0001, 8'h00, 14'h010, 4'b0000, 4'hF, 2'd0, 14'h000);
      add(4'b0001, 8'h00, 14'h010, 4'b0000, 4'hF, 2'd0, 14'h000);
      add(4'b0001, 8'h00, 14'h010, 4'b0001, 4'hF, 2'd0, 14'h000);
      add(4'b0000, 8'h00, 14'h010, 4'b0000, 4'h3, 2'd0, 14'h010);
      add(4'b0000, 8'h00, 14'h010, 4'b0000, 4'hF, 2'd0, 14'h000);
      // WR -> RD with tWTR=6, then RD -> WR with tRTW=3.
      set_t(4'd1, 4'd1, 4'd6, 4'd3, 6'd0);
      add(4'b0010, 8'h08, 14'h020, 4'b0010, 4'hF, 2'd0, 14'h000);
      add(4'b0010, 8'h04, 14'h020, 4'b0000, 4'h4, 2'd1, 14'h021);
      for (int i = 0; i < 4; i++) add(4'b0010, 8'h04, 14'h020, 4'b0000, 4'hF, 2'd0, 14'h000);
      add(4'b0010, 8'h04, 14'h020, 4'b0010, 4'hF, 2'd0, 14'h000);
      add(4'b0010, 8'h08, 14'h020, 4'b0000, 4'h5, 2'd1, 14'h021);
      add(4'b0010, 8'h08, 14'h020, 4'b0000, 4'hF, 2'd0, 14'h000);
      add(4'b0010, 8'h08, 14'h020, 4'b0010, 4'hF, 2'd0, 14'h000);
      add(4'b0000, 8'h08, 14'h020, 4'b0000, 4'h4, 2'd1, 14'h021);
      add(4'b0000, 8'h08, 14'h020, 4'b0000, 4'hF, 2'd0, 14'h000);
      // Five ACTs, t_rrd=1, t_faw=10.
      set_t(4'd1, 4'd1, 4'd0, 4'd0, 6'd10);
      add(4'b0001, 8'h00, 14'h050, 4'b0001, 4'hF, 2'd0, 14'h000);
      add(4'b0010, 8'h00, 14'h050, 4'b0010, 4'h3, 2'd0, 14'h050);
      add(4'b0100, 8'h00, 14'h050, 4'b0100, 4'h3, 2'd1, 14'h051);
      add(4'b1000, 8'h00, 14'h050, 4'b1000, 4'h3, 2'd2, 14'h052);
`ifdef SAL_SCHED_FAW_EN
      add(4'b0001, 8'h00, 14'h050, 4'b0000, 4'h3, 2'd3, 14'h053);
      for (int i = 0; i < 5; i++) add(4'b0001, 8'h00, 14'h050, 4'b0000, 4'hF, 2'd0, 14'h000);
      add(4'b0001, 8'h00, 14'h050, 4'b0001, 4'hF, 2'd0, 14'h000);
`else
      add(4'b0001, 8'h00, 14'h050, 4'b0001, 4'h3, 2'd3, 14'h053);
`endif
      add(4'b0000, 8'h00, 14'h050, 4'b0000, 4'h3, 2'd0, 14'h050);
      add(4'b0000, 8'h00, 14'h050, 4'b0000, 4'hF, 2'd0, 14'h000);

      // Reset state, with requests present.
      bk_req_valid_i = 4'hF;
      #12;
      chk("rst_ready", -1, 32'(bk_req_ready_o), 32'h0);
      chk("rst_pins",  -1, 32'(pins()), 32'hF);
      chk("rst_bank",  -1, 32'(dfi_bank_o), 32'h0);
      chk("rst_addr",  -1, 32'(dfi_address_o), 32'h0);
      bk_req_valid_i = '0;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         $display("step %0d valid=%b cmd=%h ready=%b pins=%b bank=%0d addr=%h",
                  i, vecs[i].valid, vecs[i].cmd, bk_req_ready_o, pins(), dfi_bank_o, dfi_address_o);
         chk("ready", i, 32'(bk_req_ready_o), 32'(vecs[i].exp_rdy));
         chk("pins",  i, 32'(pins()), 32'(vecs[i].exp_pins));
         if (vecs[i].exp_pins != 4'hF) begin
            chk("bank", i, 32'(dfi_bank_o), 32'(vecs[i].exp_bank));
            chk("addr", i, 32'(dfi_address_o), 32'(vecs[i].exp_addr));
         end
      end

      // Reset mid-stream with rrd pending.
      @(negedge clk);
      t_rrd_i = 4'd4; t_faw_i = 6'd0;
      bk_req_cmd_i = 8'h00;
      for (int b = 0; b < BK_CNT; b++) bk_req_addr_i[b*ADDR_W +: ADDR_W] = 14'h060 + 14'(b);
      bk_req_valid_i = 4'b0001;
      #1;
      $display("reset seq: ACT bank0 ready=%b", bk_req_ready_o);
      chk("rs_ready0", 100, 32'(bk_req_ready_o), 32'b0001);
      @(posedge clk);
      #1;
      bk_req_valid_i = 4'b0000;
      chk("rs_pins_act", 101, 32'(pins()), 32'h3);
      chk("rs_addr_act", 101, 32'(dfi_address_o), 32'h060);
      #1;
      rst_n = 1'b0;
      #1;
      $display("reset seq: rst_n low pins=%b", pins());
      chk("rs_pins_async", 102, 32'(pins()), 32'hF);
      chk("rs_bank_async", 102, 32'(dfi_bank_o), 32'h0);
      bk_req_valid_i = 4'b0010;
      #1;
      chk("rs_ready_in_rst", 103, 32'(bk_req_ready_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      $display("reset seq: released, ACT bank1 ready=%b", bk_req_ready_o);
      chk("rs_ready_after", 104, 32'(bk_req_ready_o), 32'b0010);
      @(posedge clk);
      #1;
      bk_req_valid_i = 4'b0000;
      chk("rs_pins_after", 105, 32'(pins()), 32'h3);
      chk("rs_bank_after", 105, 32'(dfi_bank_o), 32'h1);
      chk("rs_addr_after", 105, 32'(dfi_address_o), 32'h061);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
